// File: rtl/monitor_pio_bank_if.sv
// Register-bus bundle for monitor_pio_bank: 5-bit word address, active-low write,
// 32-bit data in both directions, zero wait states.
interface monitor_pio_bank_if;
    logic [4:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/monitor_pio_bank.sv
// Bank of NCH parallel I/O channels: output data registers, synchronised inputs,
// rising-edge capture with write-1-to-clear, per-channel interrupt masks, one level irq.
module monitor_pio_bank #(
    parameter int          WIDTH       = 32,
    parameter int          NCH         = 4,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    monitor_pio_bank_if.slave    bus,
    output logic [NCH*WIDTH-1:0] out_port,
    input  logic [NCH*WIDTH-1:0] in_port,
    output logic                 irq
);
    localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];

    logic [WIDTH-1:0]     r_data    [NCH];
    logic [WIDTH-1:0]     r_edgeCap [NCH];
    logic [WIDTH-1:0]     r_irqMask [NCH];
    logic [NCH*WIDTH-1:0] r_s1;
    logic [NCH*WIDTH-1:0] r_s2;
    logic [NCH*WIDTH-1:0] r_prev;
    logic [1:0]           r_warm;
    logic                 r_irq;

    logic [2:0]           w_chan;
    logic [1:0]           w_reg;
    logic                 w_wrEn;
    logic [WIDTH-1:0]     w_wrData;
    logic [NCH-1:0]       w_chanSel;
    logic [NCH*WIDTH-1:0] w_rise;
    logic [WIDTH-1:0]     w_rdSel;
    logic                 w_irqNext;
    logic                 w_unusedWrite;

    assign w_chan        = bus.address[4:2];
    assign w_reg         = bus.address[1:0];
    assign w_wrEn        = bus.chipselect & ~bus.write_n;
    assign w_wrData      = bus.writedata[WIDTH-1:0];
    assign w_unusedWrite = ^bus.writedata;

    // Edges are only trusted once the synchroniser has been refilled after reset,
    // so a level already high at reset release never looks like a rise.
    assign w_rise = (r_warm == 2'd3) ? (r_s2 & ~r_prev) : '0;

    always_comb begin
        w_chanSel = '0;
        for (int n = 0; n < NCH; n++) begin
            w_chanSel[n] = (int'(w_chan) == n);
        end
    end

    always_comb begin
        w_irqNext = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            w_irqNext = w_irqNext | (|(r_edgeCap[n] & r_irqMask[n]));
        end
    end

    // Channel indices at or beyond NCH select nothing and therefore read as zero.
    always_comb begin
        w_rdSel = '0;
        for (int n = 0; n < NCH; n++) begin
            if (w_chanSel[n]) begin
                case (w_reg)
                    2'd0:    w_rdSel = r_data[n];
                    2'd1:    w_rdSel = r_s2[n*WIDTH +: WIDTH];
                    2'd2:    w_rdSel = r_edgeCap[n];
                    default: w_rdSel = r_irqMask[n];
                endcase
            end
        end
        bus.readdata = 32'(w_rdSel);
    end

    always_comb begin
        out_port = '0;
        for (int n = 0; n < NCH; n++) begin
            out_port[n*WIDTH +: WIDTH] = r_data[n];
        end
    end

    assign irq = r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NCH; n++) begin
                r_data[n]    <= RESET_DATA;
                r_edgeCap[n] <= '0;
                r_irqMask[n] <= '0;
            end
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_warm <= 2'd0;
            r_irq  <= 1'b0;
        end else begin
            r_s1   <= in_port;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            r_irq <= w_irqNext;
            // The clear is applied before the OR so a coincident new edge survives.
            for (int n = 0; n < NCH; n++) begin
                if (w_wrEn && w_chanSel[n] && (w_reg == 2'd0)) begin
                    r_data[n] <= w_wrData;
                end
                if (w_wrEn && w_chanSel[n] && (w_reg == 2'd3)) begin
                    r_irqMask[n] <= w_wrData;
                end
                r_edgeCap[n] <= (r_edgeCap[n]
                                 & ~((w_wrEn && w_chanSel[n] && (w_reg == 2'd2)) ? w_wrData : '0))
                                | w_rise[n*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_monitor_pio_bank.sv
// Scoreboard bench for monitor_pio_bank: a 32-bit x 4 instance against a history-based
// reference model, plus an 8-bit x 4 instance for truncation and out-of-range channels.
module tb_monitor_pio_bank;
    localparam logic [31:0] RV = 32'hCAFE_0001;

    typedef struct {
        int          kind;
        int          ch;
        logic [31:0] exp;
        string       name;
    } sbEntry_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] inM;
    logic [127:0] outM;
    logic         irqM;
    logic [31:0]  inS;
    logic [31:0]  outS;
    logic         irqS;

    monitor_pio_bank_if mBus();
    monitor_pio_bank_if sBus();

    monitor_pio_bank #(.WIDTH(32), .NCH(4), .RESET_VALUE(RV)) dutM (
        .clk(clk), .reset(reset), .bus(mBus.slave),
        .out_port(outM), .in_port(inM), .irq(irqM)
    );

    monitor_pio_bank #(.WIDTH(8), .NCH(4), .RESET_VALUE(32'h0000_01FF)) dutS (
        .clk(clk), .reset(reset), .bus(sBus.slave),
        .out_port(outS), .in_port(inS), .irq(irqS)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    sbEntry_t sbQ[$];

    // Reference model: registers per channel, in_port samples newest-first, edges since reset.
    logic [31:0]  mData [4];
    logic [31:0]  mCap  [4];
    logic [31:0]  mMask [4];
    logic [127:0] mHist [3];
    int           mCycles = 0;
    logic         mIrq = 1'b0;
    logic [127:0] mRise;
    logic         mAny;
    logic         mWr;
    logic [31:0]  mClr;

    always @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                mData[c] = RV;
                mCap[c]  = 32'h0;
                mMask[c] = 32'h0;
            end
            for (int k = 0; k < 3; k++) mHist[k] = '0;
            mCycles = 0;
            mIrq    = 1'b0;
        end else begin
            mAny = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if ((mCap[c] & mMask[c]) != 32'h0) mAny = 1'b1;
            end
            // A bit rose if it was 0 three samples ago and 1 two samples ago.
            mRise = (mCycles >= 3) ? (mHist[1] & ~mHist[2]) : '0;
            mWr   = mBus.chipselect && !mBus.write_n;
            for (int c = 0; c < 4; c++) begin
                if (mWr && int'(mBus.address[4:2]) == c) begin
                    case (mBus.address[1:0])
                        2'd0:    mData[c] = mBus.writedata;
                        2'd3:    mMask[c] = mBus.writedata;
                        default: ;
                    endcase
                end
                mClr = (mWr && int'(mBus.address[4:2]) == c && mBus.address[1:0] == 2'd2)
                       ? mBus.writedata : 32'h0;
                mCap[c] = (mCap[c] & ~mClr) | mRise[c*32 +: 32];
            end
            mHist[2] = mHist[1];
            mHist[1] = mHist[0];
            mHist[0] = inM;
            mCycles++;
            mIrq = mAny;
        end
    end

    function automatic logic [31:0] modelRead(input logic [4:0] a);
        int ch;
        ch = int'(a[4:2]);
        if (ch >= 4) return 32'h0;
        case (a[1:0])
            2'd0:    return mData[ch];
            2'd1:    return mHist[1][ch*32 +: 32];
            2'd2:    return mCap[ch];
            default: return mMask[ch];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: drains every expectation queued for this cycle, away from the active edge.
    sbEntry_t    e;
    logic [31:0] act;
    always @(negedge clk) begin
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            case (e.kind)
                0:       act = mBus.readdata;
                1:       act = {31'b0, irqM};
                2:       act = outM[e.ch*32 +: 32];
                3:       act = sBus.readdata;
                default: act = {24'b0, outS[e.ch*8 +: 8]};
            endcase
            checkOutput(e.name, act, e.exp);
        end
    end

    task automatic pushExp(input int kind, input int ch, input logic [31:0] exp, input string name);
        sbEntry_t n;
        n.kind = kind;
        n.ch   = ch;
        n.exp  = exp;
        n.name = name;
        sbQ.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cs, input logic wrN, input logic [4:0] addr, input logic [31:0] wd);
        mBus.chipselect = cs;
        mBus.write_n    = wrN;
        mBus.address    = addr;
        mBus.writedata  = wd;
    endtask

    task automatic writeReg(input logic [4:0] addr, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, addr, wd);
        tick();
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
    endtask

    task automatic readReg(input logic [4:0] addr, input string name);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
        pushExp(0, 0, modelRead(addr), name);
        tick();
    endtask

    task automatic readCheck(input logic [4:0] addr, input logic [31:0] exp, input string name);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
        pushExp(0, 0, exp, name);
        tick();
    endtask

    task automatic writeSmall(input logic [4:0] addr, input logic [31:0] wd);
        sBus.chipselect = 1'b1;
        sBus.write_n    = 1'b0;
        sBus.address    = addr;
        sBus.writedata  = wd;
        tick();
        sBus.chipselect = 1'b0;
        sBus.write_n    = 1'b1;
    endtask

    task automatic readSmall(input logic [4:0] addr, input logic [31:0] exp, input string name);
        sBus.address = addr;
        pushExp(3, 0, exp, name);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [4:0]  ra;
    logic [31:0] rd;
    int          bitIdx;

    initial begin
        reset = 1'b1;
        inM   = '0;
        inS   = '0;
        applyStimulus(1'b0, 1'b1, 5'h0, 32'h0);
        sBus.chipselect = 1'b0;
        sBus.write_n    = 1'b1;
        sBus.address    = 5'h0;
        sBus.writedata  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of both instances.
        pushExp(1, 0, 32'h0, "rst_irq");
        pushExp(2, 1, RV, "rst_out_ch1");
        pushExp(4, 1, 32'hFF, "s_rst_out_ch1");
        readCheck(5'h00, RV, "rst_data_ch0");
        readCheck(5'h0E, 32'h0, "rst_cap_ch3");
        readCheck(5'h0F, 32'h0, "rst_mask_ch3");
        readSmall(5'h04, 32'hFF, "s_rst_data_ch1");

        // Channel 2 data write, other channels untouched.
        writeReg(5'h08, 32'hA5A5_A5A5);
        pushExp(2, 2, 32'hA5A5_A5A5, "ch2_out");
        pushExp(2, 0, RV, "ch0_out_kept");
        pushExp(2, 1, RV, "ch1_out_kept");
        pushExp(2, 3, RV, "ch3_out_kept");
        readCheck(5'h08, 32'hA5A5_A5A5, "ch2_readback");

        // 8-bit instance: truncation and out-of-range channel.
        writeSmall(5'h00, 32'hFFFF_FF3C);
        pushExp(4, 0, 32'h3C, "s_ch0_out");
        readSmall(5'h00, 32'h0000_003C, "s_ch0_readback");
        writeSmall(5'h14, 32'h0000_0077);
        readSmall(5'h14, 32'h0, "s_ch5_data");
        readSmall(5'h17, 32'h0, "s_ch5_mask");
        pushExp(4, 1, 32'hFF, "s_ch1_out_kept");
        pushExp(4, 0, 32'h3C, "s_ch0_out_kept");
        tick();

        // End-to-end latency of a rise on in_port bit 32.
        writeReg(5'h07, 32'h1);
        inM[32] = 1'b1;
        readCheck(5'h06, 32'h0, "lat_cap_pre");
        readCheck(5'h05, 32'h0, "lat_in_e1");
        pushExp(1, 0, 32'h0, "lat_irq_e2");
        readCheck(5'h05, 32'h1, "lat_in_e2");
        pushExp(1, 0, 32'h0, "lat_irq_e3");
        readCheck(5'h06, 32'h1, "lat_cap_e3");
        pushExp(1, 0, 32'h1, "lat_irq_e4");
        tick();
        writeReg(5'h06, 32'h1);
        pushExp(1, 0, 32'h1, "w1c_irq_lag");
        readCheck(5'h06, 32'h0, "w1c_cap_clear");
        pushExp(1, 0, 32'h0, "w1c_irq_low");
        tick();

        // W1C coinciding with a fresh edge on the same bit: the edge wins.
        inM[32] = 1'b0;
        repeat (4) tick();
        inM[32] = 1'b1;
        repeat (3) tick();
        inM[32] = 1'b0;
        tick();
        tick();
        inM[32] = 1'b1;
        tick();
        tick();
        writeReg(5'h06, 32'h1);
        pushExp(1, 0, 32'h1, "race_irq_e8");
        readCheck(5'h06, 32'h1, "race_cap_kept");
        pushExp(1, 0, 32'h1, "race_irq_hold");
        tick();
        writeReg(5'h06, 32'h1);
        tick();
        pushExp(1, 0, 32'h0, "race_irq_cleared");
        tick();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            ra = 5'($urandom_range(31, 0));
            rd = $urandom;
            if ($urandom_range(3, 0) == 0) applyStimulus(1'($urandom_range(1, 0)), 1'b0, ra, rd);
            else                           applyStimulus(1'($urandom_range(1, 0)), 1'b1, ra, rd);
            if ($urandom_range(3, 0) == 0) begin
                bitIdx = $urandom_range(127, 0);
                inM[bitIdx] = ~inM[bitIdx];
            end
            pushExp(0, 0, modelRead(ra), "rand_read");
            pushExp(1, 0, {31'b0, mIrq}, "rand_irq");
            if (i % 16 == 0) pushExp(2, (i / 16) % 4, mData[(i / 16) % 4], "rand_out");
            tick();
        end
        applyStimulus(1'b0, 1'b1, 5'h0, 32'h0);
        readReg(5'h06, "rand_tail_cap");

        // Reset while irq is high and DATA holds 0x1234; reset beats a coincident write.
        inM = '0;
        writeReg(5'h07, 32'h1);
        writeReg(5'h06, 32'hFFFF_FFFF);
        repeat (4) tick();
        inM[32] = 1'b1;
        repeat (4) tick();
        writeReg(5'h00, 32'h0000_1234);
        pushExp(1, 0, 32'h1, "pre_rst_irq");
        readCheck(5'h00, 32'h0000_1234, "pre_rst_data");
        applyStimulus(1'b1, 1'b0, 5'h00, 32'h0000_FFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'h0, 32'h0);
        pushExp(1, 0, 32'h0, "mid_rst_irq");
        pushExp(2, 0, RV, "mid_rst_out0");
        readCheck(5'h00, RV, "mid_rst_data");
        readCheck(5'h07, 32'h0, "mid_rst_mask");

        // Level already high through reset release must not be captured.
        inM = '1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        writeReg(5'h03, 32'hFFFF_FFFF);
        writeReg(5'h07, 32'hFFFF_FFFF);
        writeReg(5'h0B, 32'hFFFF_FFFF);
        writeReg(5'h0F, 32'hFFFF_FFFF);
        readCheck(5'h01, 32'hFFFF_FFFF, "hi_input_ch0");
        for (int i = 0; i < 10; i++) begin
            pushExp(1, 0, 32'h0, "hi_irq");
            readCheck(5'((i % 4) * 4 + 2), 32'h0, "hi_cap");
        end

        tick();
        if (sbQ.size() != 0) begin
            checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'h0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
